// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 4-address CPU register window (data, status).
// Received bytes are held until an addr-0 read; irq follows the ready flag.
//
// state   | meaning
// IDLE    | line idle, waiting for a high-to-low edge on RXD
// START   | timing to the start-bit centre to reject glitches
// DATA    | sampling 8 data bits, LSB first, one per bit period
// STOP    | sampling the stop bit, then publishing the byte and flags
module uart_rx #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       rw,
    input  logic [1:0] addr,
    input  logic       RXD,
    output logic [7:0] data_out,
    output logic       irq
);

    localparam int BIT_CYC  = CLK_HZ / BAUD;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CW       = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;

    localparam logic [CW-1:0] HALF_END = CW'(HALF_CYC - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(BIT_CYC - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic          sync1_q, rx_s_q, rx_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_ready_q, rx_ready_d;
    logic          overrun_q, overrun_d;
    logic          ferr_q, ferr_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          fall, rd_data, stop_done;

    assign fall    = rx_q & ~rx_s_q;
    assign rd_data = cs & rw & (addr == 2'd0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        stop_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_END) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_END) begin
                    shreg_d = {rx_s_q, shreg_q[7:1]};
                    cnt_d   = '0;
                    if (idx_q == 3'd7) state_d = S_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                if (cnt_q == BIT_END) begin
                    stop_done = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    // Read-clear is applied first so a frame finishing on the same edge survives it.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_ready_d = rx_ready_q;
        overrun_d  = overrun_q;
        ferr_d     = ferr_q;
        if (rd_data) begin
            rx_ready_d = 1'b0;
            overrun_d  = 1'b0;
            ferr_d     = 1'b0;
        end
        if (stop_done) begin
            rx_data_d  = shreg_q;
            rx_ready_d = 1'b1;
            if (!rx_s_q) ferr_d = 1'b1;
            if (rx_ready_q && !rd_data) overrun_d = 1'b1;
        end
    end

    always_comb begin
        data_out_d = data_out_q;
        if (cs && rw) begin
            case (addr)
                2'd0:    data_out_d = rx_data_q;
                2'd1:    data_out_d = {4'b0000, ferr_q, overrun_q, rx_ready_q, 1'b0};
                default: data_out_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_q       <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= 3'd0;
            shreg_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_ready_q <= 1'b0;
            overrun_q  <= 1'b0;
            ferr_q     <= 1'b0;
            data_out_q <= 8'h00;
        end else begin
            sync1_q    <= RXD;
            rx_s_q     <= sync1_q;
            rx_q       <= rx_s_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            rx_data_q  <= rx_data_d;
            rx_ready_q <= rx_ready_d;
            overrun_q  <= overrun_d;
            ferr_q     <= ferr_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;
    assign irq      = rx_ready_q;

endmodule
